// File: rtl/vec_argmax.sv
// Streaming arg-max: reduces each M-element signed vector to its maximum
// and the lowest index holding it, behind a one-entry valid/ready output slot.
module vec_argmax #(
  parameter int M  = 5,
  parameter int T  = 9,
  parameter int IW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic signed [T-1:0] data_in,
  output logic                m_valid,
  input  logic                m_ready,
  output logic signed [T-1:0] data_out,
  output logic [IW-1:0]       out_idx
);

  localparam logic [IW-1:0] LAST_IDX = IW'(M - 1);

  logic [IW-1:0]       cnt_q, cnt_d;
  logic signed [T-1:0] rmax_q, rmax_d;
  logic [IW-1:0]       ridx_q, ridx_d;
  logic                m_valid_q, m_valid_d;
  logic signed [T-1:0] dout_q, dout_d;
  logic [IW-1:0]       oidx_q, oidx_d;

  logic                is_first;
  logic                is_last;
  logic                accept;
  logic                greater;
  logic signed [T-1:0] cand_max;
  logic [IW-1:0]       cand_idx;

  assign is_first = (cnt_q == '0);
  assign is_last  = (cnt_q == LAST_IDX);

  // Only the closing element of a vector needs the output slot to be free.
  assign s_ready  = !is_last || !m_valid_q || m_ready;
  assign accept   = s_valid && s_ready;

  // Strict compare keeps the earlier index on ties.
  assign greater  = (data_in > rmax_q);

  always_comb begin
    cand_max = rmax_q;
    cand_idx = ridx_q;
    if (is_first) begin
      cand_max = data_in;
      cand_idx = '0;
    end else if (greater) begin
      cand_max = data_in;
      cand_idx = cnt_q;
    end
  end

  always_comb begin
    cnt_d     = cnt_q;
    rmax_d    = rmax_q;
    ridx_d    = ridx_q;
    m_valid_d = m_valid_q;
    dout_d    = dout_q;
    oidx_d    = oidx_q;

    if (accept) begin
      cnt_d  = is_last ? '0 : cnt_q + 1'b1;
      rmax_d = cand_max;
      ridx_d = cand_idx;
    end

    if (accept && is_last) begin
      m_valid_d = 1'b1;
      dout_d    = cand_max;
      oidx_d    = cand_idx;
    end else if (m_valid_q && m_ready) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      rmax_q    <= '0;
      ridx_q    <= '0;
      m_valid_q <= 1'b0;
      dout_q    <= '0;
      oidx_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      rmax_q    <= rmax_d;
      ridx_q    <= ridx_d;
      m_valid_q <= m_valid_d;
      dout_q    <= dout_d;
      oidx_q    <= oidx_d;
    end
  end

  assign m_valid  = m_valid_q;
  assign data_out = dout_q;
  assign out_idx  = oidx_q;

endmodule

// File: tb/tb_vec_argmax.sv
// Self-checking bench for vec_argmax (M=5, T=9): table vectors, directed
// stall/reset sequences and a random soak against a queue-based model.
module tb_vec_argmax;

  localparam int M  = 5;
  localparam int T  = 9;
  localparam int IW = 3;

  logic                clk;
  logic                reset;
  logic                s_valid;
  logic                s_ready;
  logic signed [T-1:0] data_in;
  logic                m_valid;
  logic                m_ready;
  logic signed [T-1:0] data_out;
  logic [IW-1:0]       out_idx;

  vec_argmax #(.M(M), .T(T), .IW(IW)) dut (
    .clk      (clk),
    .reset    (reset),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .data_in  (data_in),
    .m_valid  (m_valid),
    .m_ready  (m_ready),
    .data_out (data_out),
    .out_idx  (out_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model / monitor ----------------
  typedef struct {
    int max;
    int idx;
  } res_t;

  int   cur[$];
  res_t exp_q[$];
  int   n_in  = 0;
  int   n_vec = 0;
  int   n_out = 0;
  bit   hold_v = 0;
  int   hold_d, hold_i;

  function automatic res_t ref_argmax(input int v[$]);
    res_t r;
    r.max = v[0];
    r.idx = 0;
    for (int i = 1; i < v.size(); i++)
      if (v[i] > r.max) begin
        r.max = v[i];
        r.idx = i;
      end
    return r;
  endfunction

  always @(negedge clk) begin
    if (reset) begin
      cur.delete();
      exp_q.delete();
      hold_v = 0;
    end else begin
      if (hold_v) begin
        chk("stall_hold_valid", int'(m_valid), 1);
        chk("stall_hold_data", int'(data_out), hold_d);
        chk("stall_hold_idx", int'(out_idx), hold_i);
      end
      if (m_valid && m_ready) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("spurious_result", 1, 0);
        end else begin
          res_t e;
          e = exp_q.pop_front();
          chk("model_data", int'(data_out), e.max);
          chk("model_idx", int'(out_idx), e.idx);
        end
      end
      if (s_valid && s_ready) begin
        cur.push_back(int'(data_in));
        n_in++;
        if (cur.size() == M) begin
          exp_q.push_back(ref_argmax(cur));
          n_vec++;
          cur.delete();
        end
      end
      hold_v = m_valid && !m_ready;
      hold_d = int'(data_out);
      hold_i = int'(out_idx);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send_elem(input int v, output int waited);
    s_valid = 1'b1;
    data_in = T'(v);
    waited  = 0;
    while (1) begin
      @(negedge clk);
      if (s_ready === 1'b1) break;
      if (waited == 100) break;
      waited++;
    end
    if (s_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: got s_ready=%b expected 1 within 100 cycles", s_ready);
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string name;
    int    v[M];
    int    emax;
    int    eidx;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input string n, input int a, input int b, input int c,
                              input int d, input int e, input int mx, input int ix);
    vec_t t;
    t.name = n;
    t.v[0] = a; t.v[1] = b; t.v[2] = c; t.v[3] = d; t.v[4] = e;
    t.emax = mx;
    t.eidx = ix;
    return t;
  endfunction

  int w;
  int base_out, base_vec, base_in, cyc;

  initial begin
    reset   = 1'b1;
    s_valid = 1'b0;
    m_ready = 1'b0;
    data_in = '0;

    tbl.push_back(mk("tie",        3,   -7,   12,   12, -256,   12, 2));
    tbl.push_back(mk("all_neg",   -1,   -2, -256,   -5,   -1,   -1, 0));
    tbl.push_back(mk("all_min", -256, -256, -256, -256, -256, -256, 0));
    tbl.push_back(mk("max_last",   0,    0,    0,    0,  255,  255, 4));
    tbl.push_back(mk("descend",    5,    4,    3,    2,    1,    5, 0));
    tbl.push_back(mk("mid_peak", -10,   -3,  100,   -3,  -10,  100, 2));

    // reset
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("reset_m_valid", int'(m_valid), 0);
    chk("reset_data_out", int'(data_out), 0);
    chk("reset_out_idx", int'(out_idx), 0);
    chk("reset_s_ready", int'(s_ready), 1);

    // table vectors, free-flowing output
    m_ready = 1'b1;
    foreach (tbl[k]) begin
      for (int i = 0; i < M; i++) send_elem(tbl[k].v[i], w);
      s_valid = 1'b0;
      chk({tbl[k].name, "_m_valid"}, int'(m_valid), 1);
      chk({tbl[k].name, "_data"}, int'(data_out), tbl[k].emax);
      chk({tbl[k].name, "_idx"}, int'(out_idx), tbl[k].eidx);
      @(posedge clk);
      #1;
      chk({tbl[k].name, "_single_result"}, int'(m_valid), 0);
    end

    // backpressure across two back-to-back vectors
    m_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send_elem(i, w);
    chk("bp_first_valid", int'(m_valid), 1);
    chk("bp_first_data", int'(data_out), 5);
    chk("bp_first_idx", int'(out_idx), 4);
    for (int i = 9; i >= 6; i--) begin
      send_elem(i, w);
      chk("bp_early_elem_no_wait", w, 0);
    end
    s_valid = 1'b1;
    data_in = T'(5);
    @(negedge clk);
    chk("bp_last_blocked", int'(s_ready), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_last_still_blocked", int'(s_ready), 0);
    chk("bp_held_data", int'(data_out), 5);
    chk("bp_held_idx", int'(out_idx), 4);
    @(posedge clk);
    #1;
    m_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", int'(s_ready), 1);
    @(posedge clk);
    #1;
    m_ready = 1'b0;
    s_valid = 1'b0;
    chk("bp_second_valid", int'(m_valid), 1);
    chk("bp_second_data", int'(data_out), 9);
    chk("bp_second_idx", int'(out_idx), 0);
    m_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_drained", int'(m_valid), 0);

    // reset in the middle of a vector
    send_elem(100, w);
    send_elem(50, w);
    send_elem(20, w);
    s_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    base_out = n_out;
    send_elem(-3, w);
    send_elem(-1, w);
    send_elem(-2, w);
    send_elem(-9, w);
    send_elem(-4, w);
    s_valid = 1'b0;
    chk("rst_mid_valid", int'(m_valid), 1);
    chk("rst_mid_data", int'(data_out), -1);
    chk("rst_mid_idx", int'(out_idx), 1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("rst_mid_result_count", n_out - base_out, 1);

    // random soak
    base_out = n_out;
    base_vec = n_vec;
    base_in  = n_in;
    cyc = 0;
    while ((n_in - base_in) < 10000 * M && cyc < 90000) begin
      s_valid = ($urandom % 8) != 0;
      m_ready = ($urandom % 8) != 0;
      case ($urandom % 4)
        0:       data_in = ($urandom % 2) ? -9'sd256 : 9'sd255;
        1:       data_in = T'($urandom_range(0, 4) - 2);
        default: data_in = T'($urandom);
      endcase
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    m_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("soak_budget", int'(cyc < 90000), 1);
    chk("soak_vectors", n_vec - base_vec, 10000);
    chk("soak_results", n_out - base_out, 10000);
    chk("soak_pending", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vec_argmax.md
# vec_argmax

Streaming arg-max stage placed directly downstream of a `layer_M_N_P_T` neural-network layer. It consumes the layer's output stream, M signed T-bit values per input vector in element order, and emits one result per vector: the maximum value and its element index (the predicted class). Both sides use the same valid/ready handshake as the layer. A transfer occurs on a rising clock edge when valid and ready are both high.

## Interface
- `M`, default 5: elements per vector (layer output count); M ≥ 1.
- `T`, default 9: element width, signed two's complement.
- `IW`, default `(M>1) ? $clog2(M) : 1`: index width.

- `clk`  input  1  sole clock; all state updates on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `s_valid`  input  1  upstream element valid (driven by the layer's `m_valid`).
- `s_ready`  output  1  block accepts an element this cycle.
- `data_in`  input  T  signed element (the layer's `data_out`).
- `m_valid`  output  1  result valid.
- `m_ready`  input  1  downstream accepts the result.
- `data_out`  output  T  signed maximum of the vector.
- `out_idx`  output  IW  index (0..M-1) of that maximum.

## Operation
- State:
  - element counter `cnt`, range 0..M-1.
  - running maximum `rmax` (T bits, signed).
  - running index `ridx` (IW bits).
  - one-entry output register holding `m_valid`, `data_out` and `out_idx`.
- Element accept (`s_valid && s_ready`):
  - If `cnt==0`: load `rmax <= data_in`, `ridx <= 0`.
  - Otherwise: if `data_in > rmax` (signed, strict), load `rmax <= data_in`, `ridx <= cnt`.
  - Ties keep the earlier index, so the lowest index wins.
  - Then advance `cnt`: `cnt <= cnt+1`, or `cnt <= 0` when `cnt==M-1`.
- Last element (`cnt==M-1`) accepted:
  - The result is the max of `rmax` and `data_in` under the same strict-greater rule.
  - Write the result into the output register and set `m_valid <= 1`.
  - For M=1, every accepted element is a complete vector and `data_in` is the result directly.
- Output accept (`m_valid && m_ready`) without a new last element: clear `m_valid <= 0`. `data_out` and `out_idx` hold their values.
- Accepting the output and writing a new result in the same edge: the new result is loaded and `m_valid` stays 1.
- `s_ready` is combinational: `(cnt != M-1) || !m_valid || m_ready`.
  - Elements 0..M-2 of the next vector are always accepted, even while a result is stalled.
  - Only the last element waits for the output slot.
- No arithmetic widening is needed; comparisons are T-bit signed only.
- While `s_ready==0`, `data_in` is ignored; X on `data_in` is harmless.

## Timing
- Reset, effective on the rising edge while `reset==1`:
  - `cnt=0`, `rmax=0`, `ridx=0`, `m_valid=0`, `data_out=0`, `out_idx=0`.
  - `s_ready` reads 1 in the cycle after reset.
- Reset mid-vector discards the partial vector and any unconsumed result. The next accepted element is element 0.
- Latency: the result is visible (`m_valid=1`) in the cycle right after the edge that accepts the last element.
- Throughput: one element per cycle sustained while `m_ready` is high or the output is drained before each last element. No bubble between vectors.
- The output register is held stable while `m_valid && !m_ready`.
- `s_ready` depends combinationally on `m_ready`. There is no combinational path from `s_valid` to `m_valid`.

## Test plan
All scenarios use M=5, T=9.

1. **Reset.** Hold `reset` for 1 cycle and leave `s_valid` low. Required: `m_valid=0`, `data_out=0`, `out_idx=0`, `s_ready=1`.
2. **Tie.** Send {3, -7, 12, 12, -256} with `m_ready=1`. Required: exactly one result, `data_out=12`, `out_idx=2`, with `m_valid` high in the cycle after the 5th accept.
3. **All negative and extremes.**
   - {-1, -2, -256, -5, -1} → -1, index 0.
   - {-256, -256, -256, -256, -256} → -256, index 0.
   - {0, 0, 0, 0, 255} → 255, index 4.
4. **Backpressure.** Hold `m_ready=0` and stream two vectors back to back: {1,2,3,4,5} then {9,8,7,6,5}.
   - Result (5, 4) is held.
   - Elements 9, 8, 7, 6 are accepted.
   - `s_ready=0` at the second vector's last element.
   - Raise `m_ready` for one cycle. Required: the last element is accepted on that edge, (5, 4) is consumed, and (9, 0) is valid on the next cycle with `m_valid` never dropping.
5. **Reset mid-vector.** Accept 3 elements {100, 50, 20}, pulse `reset`, then send {-3, -1, -2, -9, -4}. Required: a single result of -1 at index 1. No result is produced from the aborted elements.
6. **Random soak.** Run 10000 random vectors with independent random `s_valid` and `m_ready` each cycle. Required:
   - Results match a reference model in order, with zero mismatches.
   - The result count equals the vector count.
   - No result is lost or duplicated under stall.
